// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for pipe_stage_skid: upstream beat in, downstream beat out.
// The slave modport is the stage itself; master is the surrounding environment.
interface pipe_stage_skid_if #(
  parameter int unsigned DW = 32
);
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;

  modport slave (
    input  i_valid,
    input  i_data,
    input  o_ready,
    output i_ready,
    output o_valid,
    output o_data
  );

  modport master (
    output i_valid,
    output i_data,
    output o_ready,
    input  i_ready,
    input  o_valid,
    input  o_data
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline-stage register with hold and flush.
// Define PIPE_SKID_EN to add a second (skid) entry and drive i_ready straight from a flop.
module pipe_stage_skid #(
  parameter int unsigned    DW      = 32,
  parameter logic [DW-1:0]  NOP_VAL = DW'(32'h0000_0013)
) (
  input  logic                 clk,
  input  logic                 rstn,
  pipe_stage_skid_if.slave     bus_io,
  input  logic                 hold_i,
  input  logic                 flush_i,
  output logic [1:0]           occ_o
);

  logic          main_valid_q, main_valid_d;
  logic [DW-1:0] main_data_q, main_data_d;
  logic          in_ready;
  logic          accept;
  logic          emit;

  assign emit           = main_valid_q & bus_io.o_ready & ~hold_i;
  assign accept         = bus_io.i_valid & in_ready;
  assign bus_io.i_ready = in_ready;
  assign bus_io.o_valid = main_valid_q & ~hold_i;
  // Downstream never sees stale payload while no beat is offered.
  assign bus_io.o_data  = (main_valid_q & ~hold_i) ? main_data_q : NOP_VAL;

`ifdef PIPE_SKID_EN
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_data_q, skid_data_d;

  // Registered ready: the skid entry absorbs the beat that arrives while main stalls.
  assign in_ready = ~skid_valid_q;
  assign occ_o    = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (emit) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d  = bus_io.i_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = bus_io.i_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = bus_io.i_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assert property (@(posedge clk) disable iff (!rstn) skid_valid_q |-> main_valid_q)
    else $error("skid entry valid while main entry empty");
`else
  // Ready follows the downstream side combinationally: an emit frees main on the same edge.
  assign in_ready = ~hold_i & (~main_valid_q | bus_io.o_ready);
  assign occ_o    = {1'b0, main_valid_q};

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_data_d  = bus_io.i_data;
    end else if (emit) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
    end
  end

  assert property (@(posedge clk) disable iff (!rstn) !bus_io.o_valid |-> bus_io.o_data == NOP_VAL)
    else $error("o_data not NOP_VAL while o_valid low");

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid; follows PIPE_SKID_EN to pick the expected mode.
module tb_pipe_stage_skid;

`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic       clk;
  logic       rstn;
  logic       hold;
  logic       flush;
  logic [1:0] occ;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n55      = 0;
  int unsigned n77      = 0;

  logic [31:0] q[$];

  pipe_stage_skid_if #(.DW(32)) bus ();

  pipe_stage_skid #(
    .DW      (32),
    .NOP_VAL (NOP)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus_io  (bus),
    .hold_i  (hold),
    .flush_i (flush),
    .occ_o   (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] d, input logic ordy,
                        input logic hld, input logic fl);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.o_ready = ordy;
    hold        = hld;
    flush       = fl;
  endtask

  // Check outputs against the model mid-cycle, advance the model, then move to the next cycle.
  task automatic step();
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    #1;
    exp_ready = SKID ? (q.size() < 2) : (!hold && (q.size() == 0 || bus.o_ready));
    exp_valid = (q.size() > 0) && !hold;
    exp_data  = NOP;
    if (exp_valid) exp_data = q[0];
    check_eq("i_ready", 32'(bus.i_ready), 32'(exp_ready));
    check_eq("o_valid", 32'(bus.o_valid), 32'(exp_valid));
    check_eq("o_data",  bus.o_data, exp_data);
    check_eq("occ",     32'(occ), 32'(q.size()));
    if (!flush && bus.o_valid && bus.o_ready && !hold) begin
      if (bus.o_data == 32'h55) n55++;
      if (bus.o_data == 32'h77) n77++;
    end
    if (flush) begin
      q.delete();
    end else begin
      if (exp_valid && bus.o_ready) void'(q.pop_front());
      if (bus.i_valid && exp_ready) q.push_back(bus.i_data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    check_eq("rst_o_valid", 32'(bus.o_valid), 32'd0);
    check_eq("rst_o_data",  bus.o_data, NOP);
    check_eq("rst_occ",     32'(occ), 32'd0);
    check_eq("rst_i_ready", 32'(bus.i_ready), 32'd1);
    hold = 1'b1;
    #1;
    check_eq("rst_i_ready_hold", 32'(bus.i_ready), SKID ? 32'd1 : 32'd0);
    hold = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Full-rate stream.
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
      step();
    end
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    step();

    // Back-pressure: skid absorbs 0xB; otherwise 0xB waits for o_ready.
    set_in(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    step();
    if (SKID) set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    set_in(!SKID, 32'hB, 1'b1, 1'b0, 1'b0);
    step();
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();

    // Hold: 0x55 must leave exactly once after release.
    set_in(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    step();
    set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    repeat (3) step();
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    check_eq("hold_emit_once", n55, 32'd1);

    // Accepting during hold (allowed only with skid).
    set_in(1'b1, 32'h66, 1'b0, 1'b1, 1'b0);
    repeat (3) step();
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();

    // Flush with stage full and a beat offered, then flush from empty with i_ready high.
    set_in(1'b1, 32'h21, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b1, 32'h77, 1'b0, 1'b0, 1'b1);
    step();
    set_in(1'b1, 32'h77, 1'b1, 1'b0, 1'b1);
    step();
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    repeat (2) step();
    check_eq("flush_drop_77", n77, 32'd0);

    // Flush during hold.
    set_in(1'b1, 32'h31, 1'b1, 1'b0, 1'b0);
    step();
    set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    step();
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    repeat (2) step();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      set_in(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 15) == 0));
      step();
    end
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();

    // Asynchronous reset between edges with the stage full.
    set_in(1'b1, 32'h41, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b1, 32'h42, 1'b0, 1'b0, 1'b0);
    step();
    #1;
    rstn = 1'b0;
    #1;
    check_eq("arst_o_valid", 32'(bus.o_valid), 32'd0);
    check_eq("arst_o_data",  bus.o_data, NOP);
    check_eq("arst_occ",     32'(occ), 32'd0);
    q.delete();
    #1;
    rstn = 1'b1;
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();

    set_in(1'b1, 32'h5A, 1'b1, 1'b0, 1'b0);
    step();
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    repeat (2) step();
    check_eq("drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
